// File: rtl/rx_pixel_unpacker.sv
// Unpacks 4-pixels-per-3-words RGB444 packets into a tagged pixel stream.
// Headers are validated, stalled payloads time out, and the pixel FIFO flags overflow.
//   state      | meaning
//   ST_HEADER  | waiting for a header word with the right magic and line number
//   ST_PAYLOAD | unpacking payload words of the accepted line
module rx_pixel_unpacker #(
  parameter int         LINE_PIXELS = 256,
  parameter int         MAX_LINES   = 240,
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT     = 1024,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [15:0] axiid,
  output logic        axiov,
  output logic [11:0] axiod,
  output logic [7:0]  line_y,
  output logic [7:0]  pixel_x,
  output logic        line_done,
  output logic        err_timeout,
  output logic        err_overflow
);

  localparam int WORDS = 3 * LINE_PIXELS / 4;
  localparam int WCW   = $clog2(WORDS);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = $clog2(FIFO_DEPTH + 3);
  localparam int EW    = 28;

  typedef enum logic {ST_HEADER, ST_PAYLOAD} state_t;

  state_t          r_state;
  logic [7:0]      r_line;
  logic [7:0]      r_x;
  logic [7:0]      r_residue;
  logic [1:0]      r_phase;
  logic [WCW-1:0]  r_word_cnt;
  logic [TCW-1:0]  r_tmo;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [CW-1:0]   r_count;

  logic            w_hdr_ok;
  logic            w_pay_word;
  logic            w_last_word;
  logic            w_tmo_hit;
  logic [1:0]      w_n_push;
  logic [EW-1:0]   w_push0;
  logic [EW-1:0]   w_push1;
  logic [IW-1:0]   w_idx0;
  logic [IW-1:0]   w_idx1;
  logic [IW-1:0]   w_total;
  logic [EW-1:0]   w_cat [FIFO_DEPTH+1];

  assign w_hdr_ok    = axiiv && (axiid[15:8] == MAGIC) && ({1'b0, axiid[7:0]} < 9'(MAX_LINES));
  assign w_pay_word  = (r_state == ST_PAYLOAD) && axiiv;
  assign w_last_word = (r_word_cnt == WCW'(WORDS - 1));
  assign w_tmo_hit   = (r_state == ST_PAYLOAD) && !axiiv && (r_tmo == TCW'(TIMEOUT - 1));

  // Entry layout: {pixel[11:0], x[7:0], y[7:0]}
  always_comb begin
    w_n_push = 2'd0;
    w_push0  = '0;
    w_push1  = '0;
    if (w_pay_word) begin
      case (r_phase)
        2'd0: begin
          w_n_push = 2'd1;
          w_push0  = {axiid[15:4], r_x, r_line};
        end
        2'd1: begin
          w_n_push = 2'd1;
          w_push0  = {r_residue[3:0], axiid[15:8], r_x, r_line};
        end
        default: begin
          w_n_push = 2'd2;
          w_push0  = {r_residue, axiid[15:12], r_x, r_line};
          w_push1  = {axiid[11:0], r_x + 8'd1, r_line};
        end
      endcase
    end
  end

  // Queued entries followed by this cycle's pushes; the head goes straight to the outputs.
  always_comb begin
    w_idx0  = IW'(r_count);
    w_idx1  = w_idx0 + IW'(1);
    w_total = IW'(r_count) + IW'(w_n_push);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) w_cat[i] = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < r_count) w_cat[i] = r_mem[i];
    end
    if (w_n_push != 2'd0) w_cat[w_idx0] = w_push0;
    if (w_n_push == 2'd2 && w_idx1 <= IW'(FIFO_DEPTH)) w_cat[w_idx1] = w_push1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HEADER;
      r_line       <= '0;
      r_x          <= '0;
      r_residue    <= '0;
      r_phase      <= '0;
      r_word_cnt   <= '0;
      r_tmo        <= '0;
      r_count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      axiov        <= 1'b0;
      axiod        <= '0;
      line_y       <= '0;
      pixel_x      <= '0;
      line_done    <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (r_state)
        ST_HEADER: begin
          if (w_hdr_ok) begin
            r_line     <= axiid[7:0];
            r_word_cnt <= '0;
            r_phase    <= '0;
            r_x        <= '0;
            r_tmo      <= '0;
            r_state    <= ST_PAYLOAD;
          end
        end
        default: begin
          if (axiiv) begin
            r_tmo      <= '0;
            r_word_cnt <= r_word_cnt + WCW'(1);
            r_phase    <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            r_residue  <= (r_phase == 2'd0) ? {4'h0, axiid[3:0]} : axiid[7:0];
            r_x        <= r_x + 8'(w_n_push);
            if (w_last_word) r_state <= ST_HEADER;
          end else if (w_tmo_hit) begin
            r_tmo       <= '0;
            err_timeout <= 1'b1;
            r_state     <= ST_HEADER;
          end else begin
            r_tmo <= r_tmo + TCW'(1);
          end
        end
      endcase

      if (w_total != '0) begin
        axiov                    <= 1'b1;
        {axiod, pixel_x, line_y} <= w_cat[0];
        line_done                <= (w_cat[0][15:8] == 8'(LINE_PIXELS - 1));
        for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= w_cat[i+1];
        if (w_total > IW'(FIFO_DEPTH + 1)) begin
          r_count      <= CW'(FIFO_DEPTH);
          err_overflow <= 1'b1;
        end else begin
          r_count <= CW'(w_total - IW'(1));
        end
      end else begin
        axiov     <= 1'b0;
        line_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_pixel_unpacker.sv
// Randomized packet bench for rx_pixel_unpacker against a bit-stream pixel model.
module tb_rx_pixel_unpacker;

  localparam int LP    = 256;
  localparam int WORDS = 192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axiiv = 1'b0;
  logic [15:0] axiid = 16'h0;
  logic        axiov;
  logic [11:0] axiod;
  logic [7:0]  line_y;
  logic [7:0]  pixel_x;
  logic        line_done;
  logic        err_timeout;
  logic        err_overflow;

  rx_pixel_unpacker dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .line_y(line_y), .pixel_x(pixel_x),
    .line_done(line_done), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ld;
    int          cyc;
  } obs_t;

  obs_t        got[$];
  logic [15:0] words[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int tmo_pulses = 0;
  int ld_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (axiov) got.push_back('{axiod, pixel_x, line_y, line_done, cyc});
      if (line_done && !axiov) ld_bad <= ld_bad + 1;
      if (err_timeout) tmo_pulses <= tmo_pulses + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one word for one cycle then idles to fill the spacing.
  task automatic send_word(input logic [15:0] w, input int gap);
    axiiv = 1'b1;
    axiid = w;
    @(negedge clk);
    axiiv = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  function automatic logic [15:0] get_w(input int i);
    return (i < words.size()) ? words[i] : 16'h0;
  endfunction

  // Pixel p is the p-th 12-bit slice of the payload read as one MSB-first bit stream.
  function automatic logic [11:0] model_pix(input int p);
    logic [47:0] g;
    int b;
    b = (p / 4) * 3;
    g = {get_w(b), get_w(b + 1), get_w(b + 2)};
    g = g >> (36 - 12 * (p % 4));
    return g[11:0];
  endfunction

  function automatic int model_count(input int n);
    return 4 * (n / 3) + (n % 3);
  endfunction

  task automatic make_words(input int n, input bit fixed);
    logic [15:0] pat [3];
    pat[0] = 16'h1234; pat[1] = 16'h5678; pat[2] = 16'h9ABC;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(fixed ? pat[i % 3] : 16'($urandom));
  endtask

  task automatic send_packet(input logic [15:0] hdr, input int n, input int gap);
    make_words(n, 1'b0);
    send_word(hdr, gap);
    for (int i = 0; i < n; i++) send_word(words[i], gap);
  endtask

  task automatic check_line(input logic [7:0] exp_y, input int n_words);
    int n_exp;
    int f0;
    n_exp = model_count(n_words);
    repeat (12) @(negedge clk);
    check_val("pix_count", got.size(), n_exp);
    for (int i = 0; i < got.size() && i < n_exp; i++) begin
      f0 = n_fail;
      check_val("pixel_x", got[i].x, i[7:0]);
      check_val("line_y", got[i].y, exp_y);
      check_val("axiod", got[i].pix, model_pix(i));
      check_val("line_done", got[i].ld, (i == LP - 1));
      if (n_fail != f0) break;
    end
    got.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_axiov"}, axiov, 0);
    check_val({tag, "_axiod"}, axiod, 0);
    check_val({tag, "_line_y"}, line_y, 0);
    check_val({tag, "_pixel_x"}, pixel_x, 0);
    check_val({tag, "_line_done"}, line_done, 0);
    check_val({tag, "_err_timeout"}, err_timeout, 0);
    check_val({tag, "_err_overflow"}, err_overflow, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] y;
    int last_x;
    int f0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fixed pattern line, with first-pixel latency checked by hand.
    make_words(WORDS, 1'b1);
    send_word(16'hA503, 8);
    axiiv = 1'b1;
    axiid = words[0];
    @(negedge clk);
    axiiv = 1'b0;
    check_val("lat_axiov", axiov, 1);
    check_val("lat_axiod", axiod, 12'h123);
    repeat (7) @(negedge clk);
    for (int i = 1; i < WORDS; i++) send_word(words[i], 8);
    check_line(8'd3, WORDS);
    check_val("t1_timeout", tmo_pulses, 0);
    check_val("t1_overflow", err_overflow, 0);

    // Bad magic is dropped; the following word is a header.
    send_word(16'h5A03, 8);
    check_val("rej_magic_out", got.size(), 0);
    send_packet(16'hA507, WORDS, 8);
    check_line(8'd7, WORDS);

    // Line 240 is out of range, line 239 is the last legal one.
    send_word(16'hA5F0, 8);
    check_val("rej_line_out", got.size(), 0);
    send_packet(16'hA5EF, WORDS, 8);
    check_line(8'd239, WORDS);

    // Stalled payload times out after the configured idle window.
    y = 8'($urandom_range(0, 239));
    send_packet({8'hA5, y}, 10, 8);
    repeat (1000) @(negedge clk);
    check_val("tmo_early", tmo_pulses, 0);
    repeat (100) @(negedge clk);
    check_val("tmo_pulse", tmo_pulses, 1);
    check_line(y, 10);
    y = 8'($urandom_range(0, 239));
    send_packet({8'hA5, y}, WORDS, 8);
    check_line(y, WORDS);
    check_val("tmo_total", tmo_pulses, 1);

    // Back-to-back payload overflows the FIFO; survivors keep their tags and order.
    y = 8'($urandom_range(0, 239));
    send_packet({8'hA5, y}, 30, 1);
    repeat (12) @(negedge clk);
    check_val("ovf_flag", err_overflow, 1);
    check_val("ovf_dropped", got.size() < model_count(30), 1);
    last_x = -1;
    for (int i = 0; i < got.size(); i++) begin
      f0 = n_fail;
      check_val("ovf_order", int'(got[i].x) > last_x, 1);
      check_val("ovf_axiod", got[i].pix, model_pix(int'(got[i].x)));
      check_val("ovf_line_y", got[i].y, y);
      if (i > 0) check_val("ovf_contiguous", got[i].cyc, got[i-1].cyc + 1);
      last_x = int'(got[i].x);
      if (n_fail != f0) break;
    end
    got.delete();
    repeat (50) @(negedge clk);
    check_val("ovf_sticky", err_overflow, 1);

    // Reset in the middle of a payload discards the packet and clears errors.
    y = 8'($urandom_range(0, 239));
    make_words(WORDS, 1'b0);
    send_word({8'hA5, y}, 8);
    for (int i = 0; i < 50; i++) send_word(words[i], 8);
    axiiv = 1'b1;
    axiid = words[50];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    axiiv = 1'b0;
    check_outputs_zero("midrst");
    got.delete();
    repeat (20) @(negedge clk);
    check_val("midrst_residue", got.size(), 0);
    y = 8'($urandom_range(0, 239));
    send_packet({8'hA5, y}, WORDS, 8);
    check_line(y, WORDS);
    check_val("midrst_overflow", err_overflow, 0);

    check_val("line_done_without_axiov", ld_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
